// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package inst_fetch_ctrl_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_DATA_W = 32;

  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = '0;
  localparam logic [INST_DATA_W-1:0] ZERO_WORD        = '0;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// ROM bus, decode handshake and redirect/halt controls of the fetch sequencer.
interface inst_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_inst;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              halt;
  logic              misalign;

  modport master (
    output rom_ce, rom_addr, if_valid, if_pc, if_inst, misalign,
    input  rom_inst, if_ready, br_valid, br_target, halt
  );

  modport slave (
    input  rom_ce, rom_addr, if_valid, if_pc, if_inst, misalign,
    output rom_inst, if_ready, br_valid, br_target, halt
  );

endinterface

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// Small synchronous FIFO holding {pc, inst} fetch entries; clear dominates push.
module inst_fetch_ctrl_fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] last_q;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !clear && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      // Remember the head shown this cycle so the output holds once the queue empties.
      if (!empty) last_q <= mem_q[rd_ptr_q];
      if (clear) begin
        wr_ptr_q <= rd_ptr_q;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? last_q : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the ROM and feeds decode through a fetch queue.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_W,
  parameter int unsigned       DATA_W   = INST_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       QDEPTH   = 2
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  fetch_state_e        state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                misalign_q;

  logic                redirect, pop, push, has_room;
  logic [CNT_W-1:0]    q_count;
  logic [ADDR_W+DATA_W-1:0] q_rdata;

  assign redirect = bus.br_valid && (state_q != StIdle);
  assign pop      = (q_count != '0) && bus.if_ready;
  assign has_room = (q_count < CNT_W'(QDEPTH)) || pop;
  // A redirect suppresses the fetch at the old pc in the same cycle.
  assign push     = (state_q == StRun) && !bus.br_valid && has_room;

  assign bus.rom_ce   = push ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.rom_addr = pc_q;
  assign bus.if_valid = (q_count != '0);
  assign bus.if_pc    = q_rdata[ADDR_W+DATA_W-1:DATA_W];
  assign bus.if_inst  = q_rdata[DATA_W-1:0];
  assign bus.misalign = misalign_q;

  inst_fetch_ctrl_fetch_queue #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({pc_q, bus.rom_inst}),
    .rdata (q_rdata),
    .count (q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect && (bus.br_target[1:0] != 2'b00);

      unique case (state_q)
        StIdle:  state_q <= StRun;
        StRun:   if (bus.halt) state_q <= StHalt;
        StHalt:  if (!bus.halt) state_q <= StRun;
        default: state_q <= StIdle;
      endcase

      if (redirect) begin
        pc_q <= {bus.br_target[ADDR_W-1:2], 2'b00};
      end else if (push) begin
        pc_q <= pc_q + ADDR_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl against a queue-based reference model.
module tb_inst_fetch_ctrl;

  localparam int QD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b0, rst1 = 1'b0, sel = 1'b0;
  logic        if_ready = 1'b0, br_valid = 1'b0, halt = 1'b0;
  logic [31:0] br_target = '0;

  inst_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  inst_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus0.rom_inst  = rom_word(bus0.rom_addr);
  assign bus0.if_ready  = if_ready;
  assign bus0.br_valid  = br_valid;
  assign bus0.br_target = br_target;
  assign bus0.halt      = halt;
  assign bus1.rom_inst  = rom_word(bus1.rom_addr);
  assign bus1.if_ready  = if_ready;
  assign bus1.br_valid  = br_valid;
  assign bus1.br_target = br_target;
  assign bus1.halt      = halt;

  inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .QDEPTH(QD)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(QD)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  logic        o_ce, o_valid, o_mis;
  logic [31:0] o_addr, o_pc, o_inst;
  logic [98:0] obs;

  always_comb begin
    if (sel) begin
      o_ce = bus1.rom_ce; o_addr = bus1.rom_addr; o_valid = bus1.if_valid;
      o_pc = bus1.if_pc;  o_inst = bus1.if_inst;  o_mis = bus1.misalign;
    end else begin
      o_ce = bus0.rom_ce; o_addr = bus0.rom_addr; o_valid = bus0.if_valid;
      o_pc = bus0.if_pc;  o_inst = bus0.if_inst;  o_mis = bus0.misalign;
    end
  end
  assign obs = {o_ce, o_addr, o_valid, o_pc, o_inst, o_mis};

  // Reference model: state 0=idle 1=run 2=halt, queue of fetched {pc, inst}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc, m_last_pc, m_last_inst;
  logic        m_mis;
  int          m_state;
  int          n_checks = 0, n_pass = 0;

  task automatic m_reset(input logic [31:0] rpc);
    mq.delete();
    m_pc = rpc; m_last_pc = '0; m_last_inst = '0; m_mis = 1'b0; m_state = 0;
  endtask

  function automatic logic exp_ce();
    return (m_state == 1) && !br_valid && ((mq.size() < QD) || (mq.size() != 0 && if_ready));
  endfunction

  function automatic logic [98:0] exp_vec();
    logic [31:0] hp, hi;
    if (mq.size() != 0) begin
      hp = mq[0].pc; hi = mq[0].inst;
    end else begin
      hp = m_last_pc; hi = m_last_inst;
    end
    return {exp_ce(), m_pc, mq.size() != 0, hp, hi, m_mis};
  endfunction

  task automatic m_step();
    logic   ce, pop;
    entry_t e;
    ce  = exp_ce();
    pop = (mq.size() != 0) && if_ready;
    if (mq.size() != 0) begin
      m_last_pc = mq[0].pc; m_last_inst = mq[0].inst;
    end
    m_mis = 1'b0;
    if (br_valid && m_state != 0) begin
      mq.delete();
      m_pc  = br_target & 32'hFFFF_FFFC;
      m_mis = (br_target[1:0] != 2'b00);
    end else begin
      if (pop) void'(mq.pop_front());
      if (ce) begin
        e.pc = m_pc; e.inst = rom_word(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    case (m_state)
      0:       m_state = 1;
      1:       if (halt) m_state = 2;
      default: if (!halt) m_state = 1;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  // Entered and left at a falling edge with reset just released.
  task automatic do_reset(input logic which, input logic [31:0] rpc);
    sel = which;
    if (which) rst1 = 1'b1; else rst0 = 1'b1;
    m_reset(rpc);
    repeat (2) @(negedge clk);
    if (which) rst1 = 1'b0; else rst0 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
    m_reset(32'h0);
    @(negedge clk); #1;
    n_checks++;
    if (obs === 99'h0) n_pass++;
    else $display("FAIL reset_values: got %h want %h", obs, 99'h0);
    @(negedge clk);
    rst0 = 1'b0; if_ready = 1'b1; br_valid = 1'b1; br_target = 32'h80;
    #1;
    n_checks++;
    if (o_ce === 1'b0 && o_addr === 32'h0 && o_valid === 1'b0) n_pass++;
    else $display("FAIL idle_cycle: got ce=%b addr=%h valid=%b want 0 0 0", o_ce, o_addr, o_valid);
    tick();
    br_valid = 1'b0; #1;
    n_checks++;
    if (o_addr === 32'h0 && o_ce === 1'b1 && o_mis === 1'b0) n_pass++;
    else $display("FAIL idle_redirect_ignored: got addr=%h ce=%b mis=%b want 0 1 0",
                  o_addr, o_ce, o_mis);
  endtask

  task automatic test_stream();
    logic [31:0] got_pc[$], got_inst[$];
    int first = -1;
    do_reset(1'b0, 32'h0);
    if_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL stream_cycle%0d: got %h want %h", k, obs, exp_vec());
      if (o_valid && first < 0) first = k;
      if (o_valid && if_ready) begin got_pc.push_back(o_pc); got_inst.push_back(o_inst); end
      tick();
    end
    n_checks++;
    if (first == 2) n_pass++;
    else $display("FAIL stream_first_valid: got cycle %0d want cycle 2", first);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_pc.size() > i && got_pc[i] === 32'(4 * i) && got_inst[i] === 32'h1000_0000 + 32'(i))
        n_pass++;
      else $display("FAIL stream_entry%0d: got %0d entries, want pc %h", i, got_pc.size(), 4 * i);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_pc[$];
    int nfetch = 0;
    do_reset(1'b0, 32'h0);
    if_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL stall_cycle%0d: got %h want %h", k, obs, exp_vec());
      if (o_ce) nfetch++;
      tick();
    end
    #1;
    n_checks++;
    if (nfetch == QD && o_ce === 1'b0 && o_addr === 32'h8) n_pass++;
    else $display("FAIL stall_fill: got fetches=%0d ce=%b pc=%h want 2 0 00000008",
                  nfetch, o_ce, o_addr);
    if_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL release_cycle%0d: got %h want %h", k, obs, exp_vec());
      if (o_valid) got_pc.push_back(o_pc);
      tick();
    end
    n_checks++;
    if (got_pc.size() >= 4 && got_pc[0] === 32'h0 && got_pc[1] === 32'h4 &&
        got_pc[2] === 32'h8 && got_pc[3] === 32'hC) n_pass++;
    else $display("FAIL release_order: got %0d entries, want pc 0,4,8,c in order", got_pc.size());
  endtask

  task automatic test_redirect();
    do_reset(1'b0, 32'h0);
    if_ready = 1'b0;
    repeat (4) tick();
    br_valid = 1'b1; br_target = 32'h40; #1;
    n_checks++;
    if (obs === exp_vec() && o_ce === 1'b0) n_pass++;
    else $display("FAIL redirect_t: got %h want %h", obs, exp_vec());
    tick();
    br_valid = 1'b0; #1;
    n_checks++;
    if (o_valid === 1'b0 && o_addr === 32'h40 && o_ce === 1'b1) n_pass++;
    else $display("FAIL redirect_flush: got valid=%b addr=%h ce=%b want 0 00000040 1",
                  o_valid, o_addr, o_ce);
    tick();
    #1;
    n_checks++;
    if (o_valid === 1'b1 && o_pc === 32'h40 && o_inst === 32'h1000_0010 && o_mis === 1'b0)
      n_pass++;
    else $display("FAIL redirect_target: got valid=%b pc=%h inst=%h mis=%b want 1 40 10000010 0",
                  o_valid, o_pc, o_inst, o_mis);
    tick();
  endtask

  task automatic test_misalign();
    if_ready = 1'b1; br_valid = 1'b1; br_target = 32'h42;
    tick();
    br_valid = 1'b0; #1;
    n_checks++;
    if (o_mis === 1'b1 && obs === exp_vec()) n_pass++;
    else $display("FAIL misalign_pulse: got %h want %h", obs, exp_vec());
    tick();
    #1;
    n_checks++;
    if (o_mis === 1'b0 && o_valid === 1'b1 && o_pc === 32'h40) n_pass++;
    else $display("FAIL misalign_after: got mis=%b valid=%b pc=%h want 0 1 00000040",
                  o_mis, o_valid, o_pc);
    tick();
  endtask

  task automatic test_halt();
    logic [31:0] frozen, got_pc[$];
    do_reset(1'b0, 32'h0);
    if_ready = 1'b1;
    repeat (4) tick();
    halt = 1'b1;
    frozen = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (obs === exp_vec() && (k == 0 || o_ce === 1'b0)) n_pass++;
      else $display("FAIL halt_cycle%0d: got %h want %h", k, obs, exp_vec());
      if (k == 1) frozen = o_addr;
      tick();
    end
    halt = 1'b0; #1;
    n_checks++;
    if (o_valid === 1'b0 && o_addr === frozen && o_ce === 1'b0) n_pass++;
    else $display("FAIL halt_drained: got valid=%b addr=%h ce=%b want 0 %h 0",
                  o_valid, o_addr, o_ce, frozen);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL resume_cycle%0d: got %h want %h", k, obs, exp_vec());
      if (o_valid) got_pc.push_back(o_pc);
      tick();
    end
    n_checks++;
    if (got_pc.size() > 0 && got_pc[0] === frozen) n_pass++;
    else $display("FAIL resume_pc: got %0d entries, want first pc %h", got_pc.size(), frozen);
  endtask

  task automatic test_random();
    logic prev_br = 1'b0;
    do_reset(1'b0, 32'h0);
    for (int k = 0; k < 400; k++) begin
      if_ready  = ($urandom % 4) != 0;
      if (($urandom % 10) == 0) halt = ~halt;
      br_valid  = !prev_br && (($urandom % 8) == 0);
      br_target = $urandom;
      prev_br   = br_valid;
      #1;
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL random_cycle%0d: got %h want %h", k, obs, exp_vec());
      tick();
    end
    halt = 1'b0; br_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] got_pc[$];
    do_reset(1'b1, 32'hFFFF_FFF8);
    if_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL wrap_cycle%0d: got %h want %h", k, obs, exp_vec());
      if (o_valid) got_pc.push_back(o_pc);
      tick();
    end
    n_checks++;
    if (got_pc.size() >= 3 && got_pc[0] === 32'hFFFF_FFF8 && got_pc[1] === 32'hFFFF_FFFC &&
        got_pc[2] === 32'h0) n_pass++;
    else $display("FAIL wrap_order: got %0d entries, want pc fffffff8,fffffffc,00000000",
                  got_pc.size());
    rst1 = 1'b1; #1;
    n_checks++;
    if (o_valid === 1'b0 && o_pc === 32'h0 && o_addr === 32'hFFFF_FFF8 && o_ce === 1'b0) n_pass++;
    else $display("FAIL midstream_reset: got valid=%b pc=%h addr=%h ce=%b want 0 0 fffffff8 0",
                  o_valid, o_pc, o_addr, o_ce);
    @(negedge clk);
    do_reset(1'b1, 32'hFFFF_FFF8);
    got_pc.delete();
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL restart_cycle%0d: got %h want %h", k, obs, exp_vec());
      if (o_valid) got_pc.push_back(o_pc);
      tick();
    end
    n_checks++;
    if (got_pc.size() > 0 && got_pc[0] === 32'hFFFF_FFF8) n_pass++;
    else $display("FAIL restart_pc: got %0d entries, want first pc fffffff8", got_pc.size());
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_halt();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
